// File: rtl/sign_mag_decoder.sv
// sign_mag_decoder
//   Converts a WIDTH-bit two's-complement operand into sign + unsigned
//   magnitude. The conversion is bit-serial: one operand bit per clock, LSB
//   first, using the "copy up to and including the first 1, then invert"
//   rule for negative operands. One operand is in flight at a time.
//
// Ports
//   clk        : clock, all state changes on its rising edge
//   rst        : synchronous active-high reset
//   in_valid   : data_in carries an operand this cycle
//   in_ready   : block can accept an operand (IDLE only)
//   data_in    : signed two's-complement operand, WIDTH bits
//   out_valid  : sign/magnitude/out_ovf are valid (DONE only)
//   out_ready  : consumer takes the result this cycle
//   sign       : 1 = operand was negative
//   magnitude  : unsigned absolute value of the operand, WIDTH bits
//   out_ovf    : operand was the most negative value (magnitude = 2^(WIDTH-1))
module sign_mag_decoder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] data_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             sign,
  output logic [WIDTH-1:0] magnitude,
  output logic             out_ovf
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [WIDTH-1:0] r_shreg;
  logic [CNT_W-1:0] r_cnt;
  logic             r_seen;
  logic             r_sign;
  logic [WIDTH-1:0] r_mag;
  logic             r_ovf;

  logic             w_accept;
  logic             w_last;
  logic             w_mag_bit;

  // Magnitude bit for one serial step: negative operands are copied up to and
  // including their lowest set bit, every later bit is inverted.
  function automatic logic f_mag_bit(input logic neg, input logic seen,
                                     input logic b);
    return (neg & seen) ? ~b : b;
  endfunction

  assign w_accept  = (r_state == S_IDLE) & in_valid;
  assign w_last    = (r_state == S_SHIFT) & (r_cnt == LAST_BIT);
  assign w_mag_bit = f_mag_bit(r_sign, r_seen, r_shreg[0]);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and handshake outputs
  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_state_nxt = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (w_last) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Datapath: latch on accept, one serial step per SHIFT cycle, hold in DONE
  always_ff @(posedge clk) begin
    if (rst) begin
      r_shreg <= '0;
      r_cnt   <= '0;
      r_seen  <= 1'b0;
      r_sign  <= 1'b0;
      r_mag   <= '0;
      r_ovf   <= 1'b0;
    end else if (w_accept) begin
      r_shreg <= data_in;
      r_cnt   <= '0;
      r_seen  <= 1'b0;
      r_sign  <= data_in[WIDTH-1];
      // The most negative value is the only operand whose magnitude does not
      // fit back into a positive signed WIDTH-bit number.
      r_ovf   <= (data_in == MOST_NEG);
    end else if (r_state == S_SHIFT) begin
      // Magnitude fills from the MSB end so bit 0 lands at bit 0 after
      // WIDTH steps.
      r_mag   <= {w_mag_bit, r_mag[WIDTH-1:1]};
      r_shreg <= {1'b0, r_shreg[WIDTH-1:1]};
      r_seen  <= r_seen | r_shreg[0];
      r_cnt   <= r_cnt + 1'b1;
    end
  end

  assign sign      = r_sign;
  assign magnitude = r_mag;
  assign out_ovf   = r_ovf;

endmodule

// File: tb/tb_sign_mag_decoder.sv
module tb_sign_mag_decoder;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] data_in;
  logic       out_valid;
  logic       out_ready;
  logic       sign;
  logic [7:0] magnitude;
  logic       out_ovf;

  int total = 0;
  int bad   = 0;

  sign_mag_decoder #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .data_in   (data_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sign      (sign),
    .magnitude (magnitude),
    .out_ovf   (out_ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] d;
    logic       s;
    logic [7:0] m;
    logic       o;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full transaction from IDLE: accept d, wait for DONE, optionally stall
  // for 'stall' cycles, then hand the result off. With noise set, in_valid,
  // data_in and out_ready are scrambled while the conversion is running.
  task automatic do_txn(input logic [7:0] d, input int stall, input bit noise,
                        output logic s, output logic [7:0] m, output logic o,
                        output int lat);
    int guard = 0;
    s = 1'b0; m = 8'h00; o = 1'b0; lat = -1;
    while (!in_ready && guard < 20) begin
      tick();
      guard++;
    end
    if (!in_ready) begin
      check("ready_timeout", 32'(in_ready), 32'd1);
      return;
    end
    in_valid = 1'b1;
    data_in  = d;
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (lat < 40) begin
      if (noise) begin
        in_valid  = 1'($urandom_range(0, 1));
        data_in   = 8'($urandom);
        out_ready = 1'($urandom_range(0, 1));
      end
      tick();
      lat++;
      if (out_valid) break;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    if (!out_valid) begin
      check("done_timeout", 32'(out_valid), 32'd1);
      return;
    end
    s = sign;
    m = magnitude;
    o = out_ovf;
    for (int k = 0; k < stall; k++) begin
      if (noise) begin
        in_valid = 1'($urandom_range(0, 1));
        data_in  = 8'($urandom);
      end
      tick();
      check("stall_mag", 32'(magnitude), 32'(m));
      check("stall_in_ready", 32'(in_ready), 32'd0);
      check("stall_out_valid", 32'(out_valid), 32'd1);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d",
             total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t       vt[8];
    logic       s;
    logic [7:0] m;
    logic       o;
    int         lat;
    int         acc[$];
    logic [8:0] res[$];
    logic       pre;
    int         npulse;
    int         guard;

    vt[0] = '{d: 8'hFB, s: 1'b1, m: 8'h05, o: 1'b0};
    vt[1] = '{d: 8'h7F, s: 1'b0, m: 8'h7F, o: 1'b0};
    vt[2] = '{d: 8'h00, s: 1'b0, m: 8'h00, o: 1'b0};
    vt[3] = '{d: 8'h80, s: 1'b1, m: 8'h80, o: 1'b1};
    vt[4] = '{d: 8'hFF, s: 1'b1, m: 8'h01, o: 1'b0};
    vt[5] = '{d: 8'h9C, s: 1'b1, m: 8'h64, o: 1'b0};
    vt[6] = '{d: 8'h01, s: 1'b0, m: 8'h01, o: 1'b0};
    vt[7] = '{d: 8'hC0, s: 1'b1, m: 8'h40, o: 1'b0};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; data_in = 8'h00;
    repeat (3) tick();
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_sign", 32'(sign), 32'd0);
    check("rst_mag", 32'(magnitude), 32'd0);
    check("rst_ovf", 32'(out_ovf), 32'd0);
    rst = 1'b0;
    tick();

    // Directed vectors
    for (int i = 0; i < 8; i++) begin
      do_txn(vt[i].d, (i == 3) ? 2 : 0, 1'b0, s, m, o, lat);
      check("vec_latency", 32'(lat), 32'd8);
      check("vec_sign", 32'(s), 32'(vt[i].s));
      check("vec_mag", 32'(m), 32'(vt[i].m));
      check("vec_ovf", 32'(o), 32'(vt[i].o));
      check("vec_idle_ready", 32'(in_ready), 32'd1);
      check("vec_idle_valid", 32'(out_valid), 32'd0);
    end

    // Back-to-back with in_valid held high: 0x7F then 0x00
    in_valid = 1'b1; data_in = 8'h7F; out_ready = 1'b1;
    for (int c = 0; c < 30; c++) begin
      pre = in_ready;
      tick();
      if (pre && in_valid) begin
        acc.push_back(c);
        data_in = 8'h00;
        if (acc.size() == 2) in_valid = 1'b0;
      end
      if (out_valid) res.push_back({sign, magnitude});
    end
    in_valid = 1'b0; out_ready = 1'b0;
    check("b2b_accepts", 32'(acc.size()), 32'd2);
    check("b2b_results", 32'(res.size()), 32'd2);
    if (acc.size() == 2) check("b2b_spacing", 32'(acc[1] - acc[0]), 32'd10);
    if (res.size() == 2) begin
      check("b2b_res0", 32'(res[0]), 32'h07F);
      check("b2b_res1", 32'(res[1]), 32'h000);
    end

    // Back-pressure in DONE with a competing operand on in_valid
    in_valid = 1'b1; data_in = 8'h9C; out_ready = 1'b0;
    tick();
    data_in = 8'h11;
    guard = 0;
    while (!out_valid && guard < 40) begin
      tick();
      guard++;
    end
    check("bp_done_reached", 32'(out_valid), 32'd1);
    check("bp_sign", 32'(sign), 32'd1);
    check("bp_mag", 32'(magnitude), 32'h64);
    for (int k = 0; k < 5; k++) begin
      tick();
      check("bp_hold_sign", 32'(sign), 32'd1);
      check("bp_hold_mag", 32'(magnitude), 32'h64);
      check("bp_hold_ovf", 32'(out_ovf), 32'd0);
      check("bp_hold_in_ready", 32'(in_ready), 32'd0);
      check("bp_hold_out_valid", 32'(out_valid), 32'd1);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bp_release_ready", 32'(in_ready), 32'd1);
    check("bp_release_valid", 32'(out_valid), 32'd0);
    tick();
    in_valid = 1'b0;
    check("bp_second_accepted", 32'(in_ready), 32'd0);
    lat = 0;
    while (!out_valid && lat < 40) begin
      tick();
      lat++;
    end
    check("bp_second_latency", 32'(lat), 32'd8);
    check("bp_second_sign", 32'(sign), 32'd0);
    check("bp_second_mag", 32'(magnitude), 32'h11);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Reset on the 4th SHIFT cycle discards the operation
    in_valid = 1'b1; data_in = 8'hC0;
    tick();
    in_valid = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_sign", 32'(sign), 32'd0);
    check("midrst_mag", 32'(magnitude), 32'd0);
    check("midrst_ovf", 32'(out_ovf), 32'd0);
    out_ready = 1'b1;
    npulse = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (out_valid) npulse++;
    end
    out_ready = 1'b0;
    check("midrst_no_result", 32'(npulse), 32'd0);

    // Reset while holding a result in DONE clears the outputs
    in_valid = 1'b1; data_in = 8'h80;
    tick();
    in_valid = 1'b0;
    guard = 0;
    while (!out_valid && guard < 40) begin
      tick();
      guard++;
    end
    check("donerst_reached", 32'(out_valid), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("donerst_out_valid", 32'(out_valid), 32'd0);
    check("donerst_sign", 32'(sign), 32'd0);
    check("donerst_mag", 32'(magnitude), 32'd0);
    check("donerst_ovf", 32'(out_ovf), 32'd0);

    // rst together with in_valid must not accept
    rst = 1'b1; in_valid = 1'b1; data_in = 8'h55;
    tick();
    rst = 1'b0; in_valid = 1'b0;
    check("rstacc_in_ready", 32'(in_ready), 32'd1);
    tick();
    check("rstacc_in_ready2", 32'(in_ready), 32'd1);
    check("rstacc_out_valid", 32'(out_valid), 32'd0);

    // Exhaustive sweep with random stalls and input noise, against |v|
    for (int v = -128; v < 128; v++) begin
      int         av;
      logic [7:0] em;
      av = (v < 0) ? -v : v;
      em = av[7:0];
      do_txn(8'(v), int'($urandom_range(0, 3)), 1'b1, s, m, o, lat);
      check("sweep_latency", 32'(lat), 32'd8);
      check("sweep_sign", 32'(s), 32'(v < 0));
      check("sweep_mag", 32'(m), 32'(em));
      check("sweep_ovf", 32'(o), 32'(v == -128));
      repeat ($urandom_range(0, 2)) tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sign_mag_decoder.md
SIGN_MAG_DECODER -- requirements
Module: sign_mag_decoder

Interface
REQ-001 SHALL have parameter: WIDTH, default 8, operand width in bits; legal range WIDTH >= 2.
REQ-002 SHALL have port: clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port: in_valid  input  1  data_in is valid this cycle.
REQ-005 SHALL have port: in_ready  output  1  block can accept an operand.
REQ-006 SHALL have port: data_in  input  WIDTH  signed two's-complement operand.
REQ-007 SHALL have port: out_valid  output  1  sign/magnitude/out_ovf are valid.
REQ-008 SHALL have port: out_ready  input  1  consumer accepts the result this cycle.
REQ-009 SHALL have port: sign  output  1  sign of the operand (1 = negative).
REQ-010 SHALL have port: magnitude  output  WIDTH  unsigned absolute value of the operand.
REQ-011 SHALL have port: out_ovf  output  1  operand was the most negative value, so magnitude has no positive signed equivalent.

Function
REQ-012 SHALL implement a three-state FSM: IDLE, SHIFT, DONE.
REQ-013 SHALL drive in_ready = 1 only in IDLE and out_valid = 1 only in DONE.
REQ-014 SHALL accept an operand on a rising edge where state = IDLE and in_valid = 1; data_in ignored in all other cycles.
REQ-015 On accept, SHALL latch data_in into an internal shift register, latch sign = data_in[WIDTH-1], clear the bit counter and seen_one flag, and go to SHIFT.
REQ-016 In SHIFT, SHALL process one operand bit per cycle, LSB first, for exactly WIDTH cycles.
REQ-017 Per bit b: if sign = 0, output bit = b; if sign = 1, output bit = b when seen_one = 0, else ~b; then seen_one <= seen_one | b.
REQ-018 SHALL shift each output bit into magnitude from the MSB end (right shift), so after WIDTH bits magnitude = |data_in| as unsigned WIDTH-bit value.
REQ-019 On the edge processing bit WIDTH-1, SHALL transition SHIFT -> DONE; out_valid rises exactly WIDTH edges after the accept edge.
REQ-020 SHALL set out_ovf = 1 iff the latched operand equals 1 followed by WIDTH-1 zeros; then magnitude = 2^(WIDTH-1), sign = 1.
REQ-021 SHALL treat operand 0 as sign = 0, magnitude = 0, out_ovf = 0.
REQ-022 In DONE, SHALL hold sign, magnitude, out_ovf stable until out_valid & out_ready; on that edge SHALL go to IDLE.
REQ-023 Back-pressure: out_ready = 0 in DONE SHALL stall indefinitely with outputs unchanged and in_ready = 0.
REQ-024 out_ready in IDLE or SHIFT SHALL have no effect; in_valid in SHIFT or DONE SHALL have no effect and no operand SHALL be queued.
REQ-025 Minimum spacing between accepts SHALL be WIDTH + 2 cycles (accept, WIDTH shifts ending in DONE, one IDLE cycle).
REQ-026 sign and out_ovf SHALL be visible only as valid while out_valid = 1; magnitude during SHIFT is don't-care for consumers.

Reset
REQ-027 When rst = 1 at a rising edge, SHALL go to IDLE and clear magnitude, sign, out_ovf, bit counter, seen_one, shift register to 0, regardless of state.
REQ-028 After reset, SHALL show in_ready = 1, out_valid = 0, sign = 0, magnitude = 0, out_ovf = 0.
REQ-029 Reset mid-SHIFT or in DONE SHALL discard the operation; no out_valid pulse for it.
REQ-030 rst = 1 together with in_valid = 1 SHALL not accept the operand.

Verification (WIDTH = 8)
REQ-031 Accept 0xFB (-5), out_ready = 1 -> out_valid exactly 8 edges after accept, sign = 1, magnitude = 0x05, out_ovf = 0; IDLE next edge.
REQ-032 Accept 0x7F, then 0x00 -> (sign 0, mag 0x7F, ovf 0) then (sign 0, mag 0x00, ovf 0); accepts 10 cycles apart with in_valid held high.
REQ-033 Accept 0x80 -> sign = 1, magnitude = 0x80, out_ovf = 1; accept 0xFF -> sign = 1, magnitude = 0x01, out_ovf = 0.
REQ-034 Accept 0x9C (-100), hold out_ready = 0 for 5 cycles in DONE while in_valid = 1 with 0x11 -> outputs stay sign 1, mag 0x64, in_ready = 0; 0x11 not accepted until after release.
REQ-035 Accept 0xC0, assert rst on 4th SHIFT cycle -> next cycle in_ready = 1, out_valid = 0, all outputs 0; no result for 0xC0 ever appears.
REQ-036 Exhaustive sweep -128..127 with random out_ready stalls -> each result matches reference abs/sign; out_ovf only for -128.
